// File: rtl/memory_responder.sv
// memory_responder
//   Single-port 2^ADR_W x DATA_W memory acting as the responder on the CPU
//   address/data buses. A request (read or write level strobe) is accepted
//   in IDLE, held through WAIT_CYCLES wait states, committed, and completed
//   with a four-phase ready handshake.
//
//   Handshake: the requester raises read or write and holds it. ready rises
//   once the access has completed and stays high until the requester drops
//   both strobes. The responder then returns to IDLE on the next edge, and
//   only then can it accept another request.
//
//   Optional feature: define PARITY_CHECK_EN to store an even-parity bit per
//   word and report read parity mismatches (adds inject_err / parity_err).
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   adr_bus      access address, latched at acceptance
//   wr_data      write data, latched at acceptance
//   read, write  level request strobes; write wins when both are high
//   inject_err   (PARITY_CHECK_EN) invert the stored parity of this write
//   parity_err   (PARITY_CHECK_EN) read parity mismatch, valid with ready
//   rd_data      read data; holds until the next read completes
//   ready        access complete
//   busy         responder is not in IDLE
//   state_dbg    current FSM state (IDLE=0, ACCESS=1, DONE=2)
module memory_responder #(
  parameter int ADR_W       = 6,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADR_W-1:0]  adr_bus,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              read,
  input  logic              write,
`ifdef PARITY_CHECK_EN
  input  logic              inject_err,
  output logic              parity_err,
`endif
  output logic [DATA_W-1:0] rd_data,
  output logic              ready,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q;
  logic [ADR_W-1:0]    adr_q;
  logic [DATA_W-1:0]   data_q;
  logic                op_wr_q;
  logic                accept;
  logic                commit;

  logic [DATA_W-1:0]   mem [2**ADR_W];

`ifdef PARITY_CHECK_EN
  logic                par_q;
  logic                mem_par [2**ADR_W];
`endif

  // Next-state logic. The first cycle spent in DONE is the commit cycle:
  // the memory access happens at the edge that ends it, which is also the
  // edge where ready rises. That places ready right after edge
  // E+WAIT_CYCLES+1 for a request sampled at edge E, including WAIT_CYCLES=0.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (read || write) begin
          accept  = 1'b1;
          state_d = (WAIT_CYCLES == 0) ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd1) state_d = DONE;
      end
      DONE: begin
        if (!ready)                  commit  = 1'b1;
        else if (!(read || write))   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      adr_q      <= '0;
      data_q     <= '0;
      op_wr_q    <= 1'b0;
      ready      <= 1'b0;
      rd_data    <= '0;
`ifdef PARITY_CHECK_EN
      par_q      <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      // ready rises on the commit edge and falls on the edge leaving DONE.
      ready   <= (state_d == DONE) && (commit || ready);

      if (accept) begin
        adr_q   <= adr_bus;
        data_q  <= wr_data;
        op_wr_q <= write;
        cnt_q   <= WAIT_LOAD;
`ifdef PARITY_CHECK_EN
        par_q      <= (^wr_data) ^ inject_err;
        parity_err <= 1'b0;
`endif
      end else if (state_q == ACCESS) begin
        cnt_q <= cnt_q - 4'd1;
      end

      if (commit && !op_wr_q) begin
        rd_data    <= mem[adr_q];
`ifdef PARITY_CHECK_EN
        parity_err <= mem_par[adr_q] ^ (^mem[adr_q]);
`endif
      end
    end
  end

  // Storage array is deliberately not reset. commit is derived from the
  // reset state register, so no write can land while rst is held.
  always_ff @(posedge clk) begin
    if (commit && op_wr_q) begin
      mem[adr_q] <= data_q;
`ifdef PARITY_CHECK_EN
      mem_par[adr_q] <= par_q;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder
//   Directed bench for memory_responder. Two instances share clock, reset
//   and the address/data buses: index 0 uses WAIT_CYCLES=2, index 1 uses
//   WAIT_CYCLES=0. Each has its own strobes and outputs. Define
//   PARITY_CHECK_EN to also exercise the parity feature.
module tb_memory_responder;

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       adr;
  logic [7:0]       wdat;
  logic [1:0]       rd_s, wr_s, rdy, bsy;
  logic [1:0][7:0]  rdd;
  logic [1:0][1:0]  st;
`ifdef PARITY_CHECK_EN
  logic [1:0]       inj, perr;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  memory_responder #(.ADR_W(6), .DATA_W(8), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .adr_bus(adr), .wr_data(wdat),
    .read(rd_s[0]), .write(wr_s[0]),
`ifdef PARITY_CHECK_EN
    .inject_err(inj[0]), .parity_err(perr[0]),
`endif
    .rd_data(rdd[0]), .ready(rdy[0]), .busy(bsy[0]), .state_dbg(st[0])
  );

  memory_responder #(.ADR_W(6), .DATA_W(8), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst), .adr_bus(adr), .wr_data(wdat),
    .read(rd_s[1]), .write(wr_s[1]),
`ifdef PARITY_CHECK_EN
    .inject_err(inj[1]), .parity_err(perr[1]),
`endif
    .rd_data(rdd[1]), .ready(rdy[1]), .busy(bsy[1]), .state_dbg(st[1])
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  // One full four-phase transaction. lat = negedges after acceptance until
  // ready is seen (0 on timeout); bc = cycles busy was seen high meanwhile.
  // Address/data are scrambled right after acceptance to prove latching.
  task automatic access(input int k, input bit wr, input bit rd,
                        input logic [5:0] a, input logic [7:0] d, input int hold,
                        output int lat, output int bc);
    @(negedge clk);
    adr = a; wdat = d; wr_s[k] = wr; rd_s[k] = rd;
    lat = 0; bc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin adr = ~a; wdat = ~d; end
      if (bsy[k]) bc++;
      if (rdy[k]) begin lat = c; break; end
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_ready", rdy[k], 1);
      check("hold_busy", bsy[k], 1);
    end
    wr_s[k] = 1'b0; rd_s[k] = 1'b0;
    @(negedge clk);
    check("idle_ready", rdy[k], 0);
    check("idle_busy", bsy[k], 0);
  endtask

  task automatic do_write(input int k, input logic [5:0] a, input logic [7:0] d, input int exp_lat);
    int lat, bc;
    access(k, 1'b1, 1'b0, a, d, 0, lat, bc);
    check("wr_latency", lat, exp_lat);
    check("wr_busy_cycles", bc, exp_lat);
  endtask

  task automatic do_read(input int k, input logic [5:0] a, input int hold, input int exp_lat);
    int lat, bc;
    logic [7:0] e;
    access(k, 1'b0, 1'b1, a, 8'h00, hold, lat, bc);
    e = exp_q.pop_front();
    check("rd_latency", lat, exp_lat);
    check("rd_data", rdd[k], e);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, bc;
    rst = 1'b1; adr = '0; wdat = '0; rd_s = '0; wr_s = '0;
`ifdef PARITY_CHECK_EN
    inj = '0;
`endif
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_rd_data", rdd[k], 0);
      check("rst_ready", rdy[k], 0);
      check("rst_busy", bsy[k], 0);
      check("rst_state", st[k], 0);
`ifdef PARITY_CHECK_EN
      check("rst_parity_err", perr[k], 0);
`endif
    end
    rst = 1'b0;

    // Preload known contents.
    do_write(0, 6'h05, 8'h11, 4);
    do_write(0, 6'h10, 8'h22, 4);

    // Write A5 to 3F: ready after E+3, busy 4 cycles, rd_data untouched.
    access(0, 1'b1, 1'b0, 6'h3F, 8'hA5, 0, lat, bc);
    check("wr3f_latency", lat, 4);
    check("wr3f_busy_cycles", bc, 4);
    check("wr_keeps_rd_data", rdd[0], 8'h00);

    exp_q.push_back(8'hA5);
    do_read(0, 6'h3F, 0, 4);

    // Simultaneous read and write: treated as a write.
    access(0, 1'b1, 1'b1, 6'h05, 8'h77, 0, lat, bc);
    check("both_latency", lat, 4);
    check("both_rd_unchanged", rdd[0], 8'hA5);
    exp_q.push_back(8'h77);
    do_read(0, 6'h05, 0, 4);

    // Hold read for 5 cycles after ready; rd_data stays put.
    exp_q.push_back(8'hA5);
    do_read(0, 6'h3F, 5, 4);

    // Zero wait states.
    do_write(1, 6'h00, 8'h12, 2);
    exp_q.push_back(8'h12);
    do_read(1, 6'h00, 0, 2);

`ifdef PARITY_CHECK_EN
    inj[1] = 1'b1;
    do_write(1, 6'h01, 8'h3C, 2);
    inj[1] = 1'b0;
    exp_q.push_back(8'h3C);
    do_read(1, 6'h01, 0, 2);
    check("parity_err_injected", perr[1], 1);
    do_write(1, 6'h01, 8'h3C, 2);
    check("parity_err_cleared", perr[1], 0);
    exp_q.push_back(8'h3C);
    do_read(1, 6'h01, 0, 2);
    check("parity_err_clean", perr[1], 0);
`endif

    // Reset in the middle of a write of FF to 0x10.
    @(negedge clk);
    adr = 6'h10; wdat = 8'hFF; wr_s[0] = 1'b1;
    @(posedge clk);          // request accepted
    @(posedge clk);          // in ACCESS
    #2 rst = 1'b1;
    #1;
    check("midrst_rd_data", rdd[0], 0);
    check("midrst_ready", rdy[0], 0);
    check("midrst_busy", bsy[0], 0);
    check("midrst_rd_data_z", rdd[1], 0);
    @(negedge clk);
    wr_s[0] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", bsy[0], 0);
    exp_q.push_back(8'h22);
    do_read(0, 6'h10, 0, 4);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
